// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor
// Measures the period of a divided clock (mon_clk) in clk_in cycles. mon_clk
// is sampled as asynchronous data. Each period is compared against
// EXP_PERIOD +/- TOL. The block reports lock, per-period errors and
// stuck-clock timeouts.
//
// Optional feature: define CLK_MON_DUTY_EN to measure the high time of each
// period and flag duty-cycle errors. Without the macro, high_time is tied to 0.
//
// Ports:
//   clk_in       in   system clock (100MHz)
//   rst_n        in   asynchronous active-low reset
//   enable       in   monitor enable; low forces IDLE
//   clr          in   synchronous clear of err_count and timeout_flag
//   mon_clk      in   monitored clock, asynchronous to clk_in
//   period       out  last measured period in clk_in cycles
//   period_valid out  one-cycle pulse when period updates
//   high_time    out  last measured high time (0 without CLK_MON_DUTY_EN)
//   locked       out  LOCK_CNT consecutive good measurements seen
//   err_pulse    out  one-cycle pulse per error event
//   err_count    out  saturating error count
//   timeout_flag out  sticky stuck-clock indication
//   dbg_state    out  FSM state (0 IDLE, 1 ACQUIRE, 2 TRACK)
module clk_freq_monitor #(
    parameter int EXP_PERIOD = 8,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             err_pulse,
    output logic [7:0]       err_count,
    output logic             timeout_flag,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    // good_run counts 0 .. LOCK_CNT-1; reaching LOCK_CNT moves to TRACK.
    localparam int GR_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   EXP_V     = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_V     = (CNT_W+1)'(TOL);
    localparam logic [GR_W-1:0]  RUN_LAST  = GR_W'(LOCK_CNT - 1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GR_W-1:0]  good_run_q, good_run_d;
    logic             first_seen_q, first_seen_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             timeout_flag_q, timeout_flag_d;

    logic             rise;
    logic             err_evt;
    logic             is_timeout;
    logic             period_ok;
    logic             meas_ok;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   period_diff;

    assign rise    = s2_q & ~s3_q;
    assign cnt_ext = {1'b0, cnt_q};

    // Unsigned absolute difference one bit wider than cnt, so nothing wraps.
    assign period_diff = (cnt_ext >= EXP_V) ? (cnt_ext - EXP_V) : (EXP_V - cnt_ext);
    assign period_ok   = (period_diff <= TOL_V);

`ifdef CLK_MON_DUTY_EN
    localparam logic [CNT_W:0] TOL2_V = (CNT_W+1)'(2 * TOL);

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] high_time_q;
    logic [CNT_W:0]   hc2;
    logic [CNT_W:0]   duty_diff;

    assign hc2       = {hc_q, 1'b0};
    assign duty_diff = (hc2 >= cnt_ext) ? (hc2 - cnt_ext) : (cnt_ext - hc2);
    assign meas_ok   = period_ok & (duty_diff <= TOL2_V);
    assign high_time = high_time_q;

    // The rise cycle already has s2=1, so the new period starts at 1.
    always_comb begin
        hc_d = hc_q;
        if (!enable || state_q == IDLE) begin
            hc_d = '0;
        end else if (rise) begin
            hc_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (s2_q && hc_q != CNT_MAX) begin
            hc_d = hc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hc_q        <= '0;
            high_time_q <= '0;
        end else begin
            hc_q <= hc_d;
            if (enable && state_q != IDLE && rise && first_seen_q) begin
                high_time_q <= hc_q;
            end
        end
    end
`else
    assign meas_ok   = period_ok;
    assign high_time = '0;
`endif

    // Next-state logic. enable=0 overrides everything and parks in IDLE.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        good_run_d     = good_run_q;
        first_seen_d   = first_seen_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        err_evt        = 1'b0;
        is_timeout     = 1'b0;

        if (!enable) begin
            state_d      = IDLE;
            cnt_d        = '0;
            good_run_d   = '0;
            first_seen_d = 1'b0;
            locked_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = ACQUIRE;
                    cnt_d        = '0;
                    good_run_d   = '0;
                    first_seen_d = 1'b0;
                    locked_d     = 1'b0;
                end
                default: begin
                    if (rise) begin
                        cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                        if (!first_seen_q) begin
                            // The first edge only starts the period.
                            first_seen_d = 1'b1;
                        end else begin
                            period_d       = cnt_q;
                            period_valid_d = 1'b1;
                            if (meas_ok) begin
                                if (state_q == ACQUIRE) begin
                                    if (good_run_q == RUN_LAST) begin
                                        state_d    = TRACK;
                                        locked_d   = 1'b1;
                                        good_run_d = '0;
                                    end else begin
                                        good_run_d = good_run_q + 1'b1;
                                    end
                                end
                            end else begin
                                err_evt    = 1'b1;
                                good_run_d = '0;
                                locked_d   = 1'b0;
                                state_d    = ACQUIRE;
                            end
                        end
                    end else if (cnt_q == TIMEOUT_V) begin
                        err_evt      = 1'b1;
                        is_timeout   = 1'b1;
                        locked_d     = 1'b0;
                        state_d      = ACQUIRE;
                        first_seen_d = 1'b0;
                        good_run_d   = '0;
                        cnt_d        = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Status: an error event takes precedence over clr in the same cycle.
    always_comb begin
        err_pulse_d    = err_evt;
        err_count_d    = err_count_q;
        timeout_flag_d = timeout_flag_q;
        if (err_evt) begin
            if (clr) begin
                err_count_d = 8'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (clr) begin
            err_count_d = 8'd0;
        end
        if (is_timeout) begin
            timeout_flag_d = 1'b1;
        end else if (clr) begin
            timeout_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            cnt_q          <= '0;
            good_run_q     <= '0;
            first_seen_q   <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_count_q    <= 8'd0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_q           <= mon_clk;
            s2_q           <= s1_q;
            s3_q           <= s2_q;
            cnt_q          <= cnt_d;
            good_run_q     <= good_run_d;
            first_seen_q   <= first_seen_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_pulse_q    <= err_pulse_d;
            err_count_q    <= err_count_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;
    assign timeout_flag = timeout_flag_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Testbench for clk_freq_monitor. mon_clk is driven as a train of periods.
// Each period is given as a high time and a low time, in clk_in cycles.
// A reference model works on the gaps between rising edges. It predicts
// every output event: a period_valid and/or err_pulse cycle. The predicted
// events go into a queue. A monitor compares that queue with the DUT.
module tb_clk_freq_monitor;
    localparam int EXP_PERIOD = 8;
    localparam int TOL        = 1;
    localparam int LOCK_CNT   = 4;
    localparam int TIMEOUT    = 64;
    localparam int CNT_W      = 8;
`ifdef CLK_MON_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             clr = 1'b0;
    logic             mon_clk = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [CNT_W-1:0] high_time;
    logic             locked;
    logic             err_pulse;
    logic [7:0]       err_count;
    logic             timeout_flag;
    logic [1:0]       dbg_state;

    clk_freq_monitor #(
        .EXP_PERIOD(EXP_PERIOD), .TOL(TOL), .LOCK_CNT(LOCK_CNT),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .clr(clr),
        .mon_clk(mon_clk), .period(period), .period_valid(period_valid),
        .high_time(high_time), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .timeout_flag(timeout_flag), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       pv;
        logic       ep;
        logic [7:0] period;
        logic [7:0] high;
        logic       locked;
        logic [7:0] errc;
        logic       tf;
    } evt_t;
    localparam int EW = $bits(evt_t);

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_first  = 1'b0;
    bit m_locked = 1'b0;
    bit m_tf     = 1'b0;
    int m_run    = 0;
    int m_errc   = 0;
    int m_period = 0;
    int m_high   = 0;
    int last_len = 0;
    int last_h   = 0;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic push_evt(input bit pv, input bit ep);
        evt_t e;
        e.pv     = pv;
        e.ep     = ep;
        e.period = 8'(m_period);
        e.high   = 8'(m_high);
        e.locked = m_locked;
        e.errc   = 8'(m_errc);
        e.tf     = m_tf;
        exp_q.push_back(EW'(e));
    endtask

    task automatic model_status(input bit err, input bit is_to, input bit c);
        if (err) m_errc = c ? 1 : ((m_errc < 255) ? m_errc + 1 : 255);
        else if (c) m_errc = 0;
        if (is_to) m_tf = 1'b1;
        else if (c) m_tf = 1'b0;
    endtask

    // A rising edge at the end of a gap of last_len cycles.
    task automatic model_rise(input bit c);
        bit meas = 1'b0;
        bit bad  = 1'b0;
        if (!m_first) begin
            m_first = 1'b1;
        end else begin
            meas     = 1'b1;
            m_period = last_len;
            if (DUTY) m_high = last_h;
            bad = (iabs(last_len - EXP_PERIOD) > TOL) ||
                  (DUTY && iabs(2 * last_h - last_len) > 2 * TOL);
            if (bad) begin
                m_run    = 0;
                m_locked = 1'b0;
            end else if (!m_locked) begin
                m_run++;
                if (m_run >= LOCK_CNT) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                end
            end
        end
        model_status(bad, 1'b0, c);
        if (meas) push_evt(1'b1, bad);
    endtask

    // Timeouts inside a gap of len cycles. The first one comes TIMEOUT cycles
    // after the edge. Each later one comes TIMEOUT+1 cycles after the previous.
    task automatic model_gap(input int len);
        for (int t = TIMEOUT; t < len; t += TIMEOUT + 1) begin
            m_first  = 1'b0;
            m_locked = 1'b0;
            m_run    = 0;
            model_status(1'b1, 1'b1, 1'b0);
            push_evt(1'b0, 1'b1);
        end
    endtask

    // ---------------- driver tasks ----------------
    // The DUT reacts to a rise 3 edges after it is driven. So clr asserted
    // between edges 2 and 3 lands exactly on that rise's processing edge.
    task automatic drive_period(input int h, input int l, input bit c);
        model_rise(c);
        model_gap(h + l);
        last_len = h + l;
        last_h   = h;
        mon_clk  = 1'b1;
        for (int i = 1; i <= h + l; i++) begin
            @(posedge clk_in);
            #1;
            if (i == h) mon_clk = 1'b0;
            if (i == 2) clr = c;
            if (i == 3) clr = 1'b0;
        end
    endtask

    task automatic drive_low(input int n);
        mon_clk = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic set_enable(input bit en);
        enable = en;
        if (!en) begin
            m_first  = 1'b0;
            m_locked = 1'b0;
            m_run    = 0;
        end
    endtask

    task automatic restart();
        set_enable(1'b0);
        drive_low(2);
        set_enable(1'b1);
        drive_low(3);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        evt_t e;
        if (rst_n && (period_valid || err_pulse)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: pv=%0d ep=%0d period=%0d expected no event at %0t",
                         period_valid, err_pulse, period, $time);
            end else begin
                e = evt_t'(exp_q.pop_front());
                chk("period_valid", int'(period_valid), int'(e.pv));
                chk("err_pulse", int'(err_pulse), int'(e.ep));
                chk("period", int'(period), int'(e.period));
                chk("high_time", int'(high_time), int'(e.high));
                chk("locked", int'(locked), int'(e.locked));
                chk("err_count", int'(err_count), int'(e.errc));
                chk("timeout_flag", int'(timeout_flag), int'(e.tf));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_period_valid"}, int'(period_valid), 0);
        chk({tag, "_high_time"}, int'(high_time), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_err_pulse"}, int'(err_pulse), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_timeout_flag"}, int'(timeout_flag), 0);
        chk({tag, "_state"}, int'(dbg_state), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int h;
        #23;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;

        // Nominal 4H/4L: lock on the 4th measurement.
        set_enable(1'b1);
        drive_low(3);
        repeat (8) drive_period(4, 4, 1'b0);
        chk("nominal_locked", int'(locked), 1);
        chk("nominal_err_count", int'(err_count), 0);

        // One long period, then relock.
        drive_period(6, 6, 1'b0);
        repeat (5) drive_period(4, 4, 1'b0);
        chk("relock_locked", int'(locked), 1);

        // Stuck-low mon_clk: one timeout, then recovery.
        drive_period(4, 100, 1'b0);
        repeat (6) drive_period(4, 4, 1'b0);
        chk("after_timeout_flag", int'(timeout_flag), 1);

        // Plain clr on a good measurement.
        drive_period(4, 4, 1'b1);
        drive_period(4, 4, 1'b0);

        // 7/9 alternation stays within tolerance.
        repeat (4) begin
            drive_period(4, 3, 1'b0);
            drive_period(4, 5, 1'b0);
        end
        chk("alt79_locked", int'(locked), int'(m_locked));

        // Disable mid-operation holds status and drops lock.
        set_enable(1'b0);
        drive_low(3);
        chk("disable_locked", int'(locked), 0);
        chk("disable_state", int'(dbg_state), 0);
        chk("disable_period", int'(period), m_period);
        chk("disable_err_count", int'(err_count), m_errc);
        set_enable(1'b1);
        drive_low(3);

        // 6/10 alternation: every measurement is an error.
        repeat (4) begin
            drive_period(3, 3, 1'b0);
            drive_period(5, 5, 1'b0);
        end
        chk("alt610_locked", int'(locked), 0);

        // Gap of exactly TIMEOUT is a measurement. A gap of TIMEOUT+1 is a timeout.
        drive_period(4, 60, 1'b0);
        drive_period(4, 4, 1'b0);
        drive_period(4, 61, 1'b0);
        drive_period(4, 4, 1'b0);
        drive_period(4, 4, 1'b0);

        // clr coinciding with an error event.
        drive_period(6, 6, 1'b0);
        drive_period(4, 4, 1'b1);
        drive_period(4, 4, 1'b0);
        chk("clr_with_err_count", int'(err_count), m_errc);

        // Saturation of err_count with random bad periods.
        repeat (305) begin
            p = ($urandom_range(0, 1) == 0) ? $urandom_range(4, 6) : $urandom_range(10, 13);
            h = $urandom_range(1, p - 1);
            drive_period(h, p - h, 1'b0);
        end
        chk("sat_err_count", int'(err_count), 255);
        drive_period(4, 4, 1'b1);

        // Random periods around nominal with random duty.
        restart();
        repeat (150) begin
            p = $urandom_range(6, 10);
            h = $urandom_range(1, p - 1);
            drive_period(h, p - h, 1'b0);
        end

        // 2H/6L: duty error per period when the duty check is built in.
        restart();
        repeat (6) drive_period(2, 6, 1'b0);

        // Asynchronous reset while locked.
        restart();
        repeat (6) drive_period(4, 4, 1'b0);
        chk("pre_reset_locked", int'(locked), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        chk("queue_drained", exp_q.size(), 0);
        #20;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
